// File: rtl/hazard_forward_unit_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
//   fwd_sel_t  - EX operand mux select codes (register file / WB / MEM)
//   hz_state_t - hazard controller FSM states
//   slot_t     - register-usage record of one in-flight instruction
//   slot_writes - true when a slot will write a given non-zero register
package hazard_pkg;

  localparam int ADDR_W = 5;  // register index width
  localparam int SEL_W  = 2;  // forward select width

  typedef enum logic [SEL_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
    logic              is_load;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
  } slot_t;

  // x0 is hard-wired to zero, so a write to it is never a forwarding source.
  // Bubbles (valid=0) never match.
  function automatic logic slot_writes(input slot_t s, input logic [ADDR_W-1:0] r);
    return s.valid & s.regwrite & (s.rd != '0) & (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_forward_select.sv
// forward_select: combinational forwarding comparator for one EX operand.
// Ports:
//   src      in  EX-stage source register index for this operand
//   mem_slot in  instruction currently in MEM
//   wb_slot  in  instruction currently in WB
//   sel      out operand mux select (MEM beats WB beats register file)
module forward_select
  import hazard_pkg::*;
(
  input  logic [ADDR_W-1:0] src,
  input  slot_t             mem_slot,
  input  slot_t             wb_slot,
  output fwd_sel_t          sel
);

  // The comparator only needs valid/regwrite/rd; the remaining slot fields
  // are carried for the rest of the tracker.
  logic unused_fields;
  assign unused_fields = &{1'b0, mem_slot.is_load, mem_slot.rs1, mem_slot.rs2,
                           wb_slot.is_load, wb_slot.rs1, wb_slot.rs2};

  always_comb begin
    sel = FWD_RF;
    if (slot_writes(mem_slot, src)) begin
      sel = FWD_MEM;  // youngest producer wins
    end else if (slot_writes(wb_slot, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: pipeline-hazard controller for the 5-stage core.
// Tracks the EX/MEM/WB instructions' register usage and produces:
//   forward_a_e / forward_b_e - EX operand mux selects
//   stall_f / stall_d         - hold PC and IF/ID
//   flush_d / flush_e         - clear IF/ID, bubble into ID/EX
//   stall_all                 - freeze EX/MEM/WB during a data-memory wait
//   state_o                   - FSM state (RUN=00, LOAD_STALL=01, MEM_WAIT=10)
// Inputs: decode-stage rs1/rs2/rd, regwrite, is_load, valid; EX branch
// outcome; data-memory ready. Reset is asynchronous, active-low.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = ADDR_W,  // slot records are sized by the package
  parameter int FWD_WIDTH      = SEL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      regwrite_d,
  input  logic                      is_load_d,
  input  logic                      valid_d,
  input  logic                      branch_taken_e,
  input  logic                      dmem_ready,
  output logic [FWD_WIDTH-1:0]      forward_a_e,
  output logic [FWD_WIDTH-1:0]      forward_b_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      stall_all,
  output logic [1:0]                state_o
);

  slot_t     ex_reg, mem_reg, wb_reg;
  slot_t     dec_slot;
  hz_state_t state_reg, state_next;
  logic      mem_wait;
  logic      load_use;

  assign dec_slot = '{valid:    valid_d,
                      rd:       rd_d,
                      regwrite: regwrite_d,
                      is_load:  is_load_d,
                      rs1:      rs1_d,
                      rs2:      rs2_d};

  // ---------------------------------------------------------------------
  // Forwarding: one comparator per EX operand
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] ex_src  [2];
  fwd_sel_t          fwd_sel [2];

  assign ex_src[0] = ex_reg.rs1;
  assign ex_src[1] = ex_reg.rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    forward_select u_sel (
      .src      (ex_src[gi]),
      .mem_slot (mem_reg),
      .wb_slot  (wb_reg),
      .sel      (fwd_sel[gi])
    );
  end

  // Selects stay constant during a memory wait because the slots are frozen.
  assign forward_a_e = fwd_sel[0];
  assign forward_b_e = fwd_sel[1];

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  // The wait is raised combinationally so the load already in MEM is held
  // on the very first cycle the memory is not ready.
  assign mem_wait = mem_reg.valid & mem_reg.is_load & ~dmem_ready;

  assign load_use = valid_d & ex_reg.valid & ex_reg.is_load & (ex_reg.rd != '0) &
                    ((ex_reg.rd == rs1_d) | (ex_reg.rd == rs2_d));

  // ---------------------------------------------------------------------
  // FSM next state and control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = RUN;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    stall_all  = 1'b0;

    if (mem_wait) begin
      // Memory wait dominates: branch and load-use are not acted on while
      // frozen; the instructions involved are still held and re-evaluate
      // once the pipeline moves again.
      stall_all  = 1'b1;
      stall_f    = 1'b1;
      stall_d    = 1'b1;
      state_next = MEM_WAIT;
    end else if (branch_taken_e) begin
      // The decode instruction is discarded, so a load-use on it is moot.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      // LOAD_STALL only ever follows a detection in RUN (or a released
      // wait); in LOAD_STALL itself EX holds the bubble, so no new hazard.
      case (state_reg)
        RUN, MEM_WAIT: state_next = LOAD_STALL;
        default:       state_next = RUN;
      endcase
    end
  end

  assign state_o = state_reg;

  // ---------------------------------------------------------------------
  // Slot tracker and state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg    <= '0;
      mem_reg   <= '0;
      wb_reg    <= '0;
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
      if (!stall_all) begin
        wb_reg  <= mem_reg;
        mem_reg <= ex_reg;
        ex_reg  <= flush_e ? slot_t'('0) : dec_slot;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Table-driven bench for hazard_forward_unit. Each table entry is one
// decode-stage instruction plus the outputs expected in that same cycle.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic       regwrite_d = 1'b0, is_load_d = 1'b0, valid_d = 1'b0;
  logic       branch_taken_e = 1'b0, dmem_ready = 1'b1;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e, stall_all;
  logic [1:0] state_o;

  hazard_forward_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .rd_d           (rd_d),
    .regwrite_d     (regwrite_d),
    .is_load_d      (is_load_d),
    .valid_d        (valid_d),
    .branch_taken_e (branch_taken_e),
    .dmem_ready     (dmem_ready),
    .forward_a_e    (forward_a_e),
    .forward_b_e    (forward_b_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .stall_all      (stall_all),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       vld;
    logic [4:0] rd, rs1, rs2;
    logic       rw, ld, br, rdy;
    logic [10:0] exp;  // {fa, fb, stall_f, stall_d, flush_d, flush_e, stall_all, state}
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [10:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic fd,
                                     input logic fe, input logic sa, input logic [1:0] st);
    return {fa, fb, sf, sd, fd, fe, sa, st};
  endfunction

  task automatic add(input string n, input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic rw, input logic ld, input logic br,
                     input logic rdy, input logic [10:0] e);
    vec_t t;
    t.name = n; t.vld = v; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.rw = rw; t.ld = ld; t.br = br; t.rdy = rdy; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic check(input string n, input logic [10:0] e);
    logic [10:0] got;
    got = {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e, stall_all, state_o};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %b required %b (fa fb sf sd fd fe sa st)", n, got, e);
    end else begin
      $display("ok   %-18s out=%b", n, got);
    end
  endtask

  // Drive one decode instruction just after the edge, queue its expectation,
  // and compare on the falling edge of the same cycle.
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    valid_d = v.vld; rd_d = v.rd; rs1_d = v.rs1; rs2_d = v.rs2;
    regwrite_d = v.rw; is_load_d = v.ld; branch_taken_e = v.br; dmem_ready = v.rdy;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check(e.name, e.exp);
  endtask

  logic [10:0] z;

  initial begin
    z = ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    //   name               v  rd  rs1 rs2 rw ld br rdy expected
    add("add_x5",           1,  5,  1,  2, 1, 0, 0, 1, z);
    add("sub_x8",           1,  8,  5,  3, 1, 0, 0, 1, z);
    add("fwd_a_mem",        0,  0,  0,  0, 0, 0, 0, 1, ex(2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00));
    add("addi_x6",          1,  6,  0,  0, 1, 0, 0, 1, z);
    add("or_x9",            1,  9,  1,  1, 1, 0, 0, 1, z);
    add("and_x10",          1, 10,  2,  6, 1, 0, 0, 1, z);
    add("fwd_b_wb",         0,  0,  0,  0, 0, 0, 0, 1, ex(2'b00, 2'b01, 0, 0, 0, 0, 0, 2'b00));
    add("addi_x6_a",        1,  6,  0,  0, 1, 0, 0, 1, z);
    add("addi_x6_b",        1,  6,  0,  0, 1, 0, 0, 1, z);
    add("xor_x11",          1, 11,  6,  6, 1, 0, 0, 1, z);
    add("fwd_mem_over_wb",  0,  0,  0,  0, 0, 0, 0, 1, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 2'b00));
    add("addi_x0",          1,  0,  1,  0, 1, 0, 0, 1, z);
    add("add_x12_x0",       1, 12,  0,  0, 1, 0, 0, 1, z);
    add("x0_guard",         0,  0,  0,  0, 0, 0, 0, 1, z);
    add("lw_x7",            1,  7,  1,  0, 1, 1, 0, 1, z);
    add("load_use",         1, 13,  7,  2, 1, 0, 0, 1, ex(2'b00, 2'b00, 1, 1, 0, 1, 0, 2'b00));
    add("load_stall_state", 1, 13,  7,  2, 1, 0, 0, 1, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b01));
    add("load_fwd_wb",      0,  0,  0,  0, 0, 0, 0, 1, ex(2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b00));
    add("lw_x7_b",          1,  7,  1,  0, 1, 1, 0, 1, z);
    add("br_over_loaduse",  1, 14,  7,  3, 1, 0, 1, 1, ex(2'b00, 2'b00, 0, 0, 1, 1, 0, 2'b00));
    add("br_state_run",     0,  0,  0,  0, 0, 0, 0, 1, z);
    add("addi_x15",         1, 15,  0,  0, 1, 0, 0, 1, z);
    add("lw_x16",           1, 16, 15,  0, 1, 1, 0, 1, z);
    add("or_x18",           1, 18, 15,  1, 1, 0, 0, 1, ex(2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00));
    add("wait_1",           1, 17, 16, 16, 1, 0, 1, 0, ex(2'b01, 2'b00, 1, 1, 0, 0, 1, 2'b00));
    add("wait_2",           1, 17, 16, 16, 1, 0, 1, 0, ex(2'b01, 2'b00, 1, 1, 0, 0, 1, 2'b10));
    add("wait_3",           1, 17, 16, 16, 1, 0, 1, 0, ex(2'b01, 2'b00, 1, 1, 0, 0, 1, 2'b10));
    add("wait_release",     1, 17, 16, 16, 1, 0, 0, 1, ex(2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b10));
    add("wait_fwd",         0,  0,  0,  0, 0, 0, 0, 1, ex(2'b01, 2'b01, 0, 0, 0, 0, 0, 2'b00));
    add("lw_x20",           1, 20,  1,  0, 1, 1, 0, 1, z);
    add("nop_a",            0,  0,  0,  0, 0, 0, 0, 1, z);
    add("wait_rst_1",       0,  0,  0,  0, 0, 0, 0, 0, ex(2'b00, 2'b00, 1, 1, 0, 0, 1, 2'b00));
    add("wait_rst_2",       0,  0,  0,  0, 0, 0, 0, 0, ex(2'b00, 2'b00, 1, 1, 0, 0, 1, 2'b10));

    #12;
    check("reset_state", z);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Reset asserted in the middle of a memory wait clears everything at once.
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait", z);
    @(negedge clk);
    check("reset_held", z);
    dmem_ready = 1'b1;
    rst_n = 1'b1;
    begin
      vec_t t;
      t.name = "post_reset"; t.vld = 0; t.rd = 0; t.rs1 = 0; t.rs2 = 0;
      t.rw = 0; t.ld = 0; t.br = 0; t.rdy = 1; t.exp = z;
      apply(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
